// File: rtl/bk_adder_pkg.sv
// Shared types and elaboration helpers for the pipelined Brent-Kung adder.
// The node-selection functions describe the prefix tree. The top module uses
// them to decide where a prefix cell sits and where a bit just passes through.
package bk_adder_pkg;

  localparam int MIN_WIDTH = 4;
  localparam int MAX_WIDTH = 64;

  // One prefix node: group generate and group propagate.
  typedef struct packed {
    logic g;
    logic p;
  } pg_t;

  // Returns 1 when n is a positive power of two.
  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

  // Stage numbering inside the prefix pipeline:
  //   0                  : input register (bitwise G/P)
  //   1 .. log2w         : up-sweep level k = stage
  //   log2w+1 .. 2log2w-1: down-sweep level d = stage - log2w
  // The down-sweep at level d closes a gap of h = 2^(log2w-1-d) bits.

  // Returns 1 when bit i receives a prefix cell in this stage.
  function automatic bit node_active(input int stage, input int i, input int log2w);
    int span;
    if (stage <= log2w) begin
      span = 1 << stage;
      return ((i + 1) % span) == 0;
    end
    span = 1 << (2 * log2w - 1 - stage);
    return (((i + 1) % (2 * span)) == span) && ((i + 1) >= 3 * span);
  endfunction

  // Returns the index of the lower-order node that bit i combines with.
  function automatic int node_lo(input int stage, input int i, input int log2w);
    if (stage <= log2w) begin
      return i - (1 << (stage - 1));
    end
    return i - (1 << (2 * log2w - 1 - stage));
  endfunction

  // Returns 1 when the combined node covers bits [i:0].
  // Its propagate is then never consumed, so a grey cell is enough.
  function automatic bit node_grey(input int stage, input int i, input int log2w);
    if (stage <= log2w) begin
      return (i + 1) == (1 << stage);
    end
    return 1'b1;
  endfunction

endpackage

// File: rtl/bk_adder_pipe_prefix_cell.sv
// Combinational prefix operator: (g_hi,p_hi) o (g_lo,p_lo).
// With GREY set, only the group generate is produced and p is tied low.
module bk_prefix_cell
  import bk_adder_pkg::*;
#(
  parameter bit GREY = 1'b0
) (
  input  pg_t hi,
  input  pg_t lo,
  output pg_t y
);

  assign y.g = hi.g | (hi.p & lo.g);
  assign y.p = GREY ? 1'b0 : (hi.p & lo.p);

endmodule

// File: rtl/bk_adder_pipe.sv
// Fully pipelined Brent-Kung adder/subtractor with valid/ready handshake.
// There is one register stage per prefix level. A single global stall (adv)
// freezes every stage while the output beat waits for its consumer.
module bk_adder_pipe
  import bk_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LOG2W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  // Stages are: input register, LOG2W up-sweep levels and LOG2W-1
  // down-sweep levels. The result register follows them, so the
  // latency is 2*LOG2W+1.
  localparam int NSTG = 2 * LOG2W;

  if (!is_pow2(WIDTH) || WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
    $fatal(1, "bk_adder_pipe: WIDTH must be a power of two in 4..64");
  end
  if (LOG2W != $clog2(WIDTH)) begin : g_bad_log2w
    $fatal(1, "bk_adder_pipe: LOG2W must equal clog2(WIDTH)");
  end

  // Global advance: the pipeline moves whenever the output slot is free or
  // is being drained this cycle. in_ready depends only on the output side.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Registered outputs of every stage, collected so the next stage can read
  // them by index.
  pg_t [WIDTH-1:0] node_chain  [NSTG];
  logic [WIDTH-1:0] p0_chain   [NSTG];
  logic             c0_chain   [NSTG];
  logic             valid_chain[NSTG];

  for (genvar s = 0; s < NSTG; s++) begin : g_stage
    pg_t [WIDTH-1:0] node_d;
    pg_t [WIDTH-1:0] node_q;
    logic [WIDTH-1:0] p0_d;
    logic [WIDTH-1:0] p0_q;
    logic             c0_d;
    logic             c0_q;
    logic             valid_d;
    logic             valid_q;

    if (s == 0) begin : g_in
      logic [WIDTH-1:0] b_eff;

      // Form bitwise generate/propagate and fold the effective carry-in into bit 0.
      always_comb begin
        b_eff   = sub ? ~b : b;
        c0_d    = sub | cin;
        valid_d = in_valid;
        p0_d    = a ^ b_eff;
        for (int i = 0; i < WIDTH; i++) begin
          node_d[i].g = a[i] & b_eff[i];
          node_d[i].p = p0_d[i];
        end
        node_d[0].g = (a[0] & b_eff[0]) | (c0_d & (a[0] | b_eff[0]));
      end
    end else begin : g_tree
      assign p0_d    = p0_chain[s-1];
      assign c0_d    = c0_chain[s-1];
      assign valid_d = valid_chain[s-1];

      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        localparam bit ACTIVE = node_active(s, i, LOG2W);
        if (ACTIVE) begin : g_cell
          localparam int LO   = node_lo(s, i, LOG2W);
          localparam bit GREY = node_grey(s, i, LOG2W);
          bk_prefix_cell #(
            .GREY(GREY)
          ) u_cell (
            .hi(node_chain[s-1][i]),
            .lo(node_chain[s-1][LO]),
            .y (node_d[i])
          );
        end else begin : g_pass
          assign node_d[i] = node_chain[s-1][i];
        end
      end
    end

    // Stage register: loads the whole beat, bubble or not, only on advance.
    always_ff @(posedge clk or posedge rst) begin
      // NOTE: datapath registers are reset as well as valid bits, so that
      // outputs read as zero out of reset; this is a flop array, not a RAM.
      if (rst) begin
        node_q  <= '0;
        p0_q    <= '0;
        c0_q    <= 1'b0;
        valid_q <= 1'b0;
      end else if (adv) begin
        // NOTE: non-blocking assignment keeps every stage sampling the
        // previous stage's old value on the same edge.
        node_q  <= node_d;
        p0_q    <= p0_d;
        c0_q    <= c0_d;
        valid_q <= valid_d;
      end
    end

    assign node_chain[s]  = node_q;
    assign p0_chain[s]    = p0_q;
    assign c0_chain[s]    = c0_q;
    assign valid_chain[s] = valid_q;
  end

  // After the last down-sweep level, every node i holds the carry out of bit i.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_d;

  // Assemble the carry vector and form the sum from the delayed propagates.
  always_comb begin
    carry[0] = c0_chain[NSTG-1];
    for (int i = 0; i < WIDTH; i++) begin
      carry[i+1] = node_chain[NSTG-1][i].g;
    end
    sum_d = p0_chain[NSTG-1] ^ carry[WIDTH-1:0];
  end

  // Result register: holds the beat while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (adv) begin
      out_valid <= valid_chain[NSTG-1];
      sum       <= sum_d;
      cout      <= carry[WIDTH];
      ovf       <= carry[WIDTH] ^ carry[WIDTH-1];
    end
  end

endmodule
